// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port B arbiter.
// Optional starvation guard for requester 1 is enabled by defining ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
package mem_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam logic       REQ_CORE   = 1'b0;
    localparam logic       REQ_LOADER = 1'b1;
    localparam logic [3:0] BE_READ    = 4'b0000;

    localparam int unsigned DEFAULT_INIT_CYCLES = 4;
    localparam int unsigned DEFAULT_MAX_WAIT    = 8;

    // Width of a counter holding values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_age_counter.sv
// Counts the cycles requester 1 has been held off; fire_o hands it the next contended cycle.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
`timescale 1ns/1ps
module mem_arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic waiting_i,
    input  logic clear_i,
    output logic fire_o
);

    localparam int unsigned CntW = cnt_width(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (waiting_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates RAM port B between the core LSU (req0) and the loader/debug master (req1),
// sequences RAM init after reset and routes read data back. Macro: ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = DEFAULT_INIT_CYCLES,
    parameter int unsigned MAX_WAIT    = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_be,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_be,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        ram_reset,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_web,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    localparam int unsigned InitW = cnt_width(INIT_CYCLES);
    localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [InitW-1:0] init_cnt_q, init_cnt_d;
    logic             pend_q, pend_d;
    logic             owner_q, owner_d;
    logic             wr_q, wr_d;

    logic run;
    logic gnt0, gnt1;
    logic starve_fire;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            if (init_cnt_q == InitLast) begin
                state_d = RUN;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end
    end

    assign run       = (state_q == RUN);
    assign ram_reset = (state_q == INIT);

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_counter (
        .clk_i     (clk),
        .rst_ni    (reset),
        .waiting_i (run && req1_valid && !gnt1),
        .clear_i   (!req1_valid || gnt1),
        .fire_o    (starve_fire)
    );
`else
    assign starve_fire = 1'b0;
`endif

    // Requester 0 has priority unless requester 1 has aged out.
    assign gnt0 = run && req0_valid && !(req1_valid && starve_fire);
    assign gnt1 = run && req1_valid && (!req0_valid || starve_fire);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Idle cycles present a read of word 0 whose result is dropped.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_web  = BE_READ;
        if (gnt0) begin
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
            ram_web  = req0_be;
        end else if (gnt1) begin
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
            ram_web  = req1_be;
        end
    end

    always_comb begin
        pend_d  = gnt0 || gnt1;
        owner_d = gnt1 ? REQ_LOADER : REQ_CORE;
        wr_d    = (ram_web != BE_READ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            pend_q     <= 1'b0;
            owner_q    <= REQ_CORE;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
        end
    end

    assign rsp0_valid = pend_q && (owner_q == REQ_CORE);
    assign rsp1_valid = pend_q && (owner_q == REQ_LOADER);
    assign rsp0_rdata = (rsp0_valid && !wr_q) ? ram_dout : '0;
    assign rsp1_rdata = (rsp1_valid && !wr_q) ? ram_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural one-cycle-latency RAM.
// Expected starvation pattern follows ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [3:0]  req0_be, req1_be;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        ram_reset;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic [3:0]  ram_web;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GuardOn = 1'b1;
`else
    localparam bit GuardOn = 1'b0;
`endif

    mem_port_arbiter #(
        .INIT_CYCLES (4),
        .MAX_WAIT    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_be    (req0_be),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_be    (req1_be),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_reset  (ram_reset),
        .ram_addr   (ram_addr),
        .ram_web    (ram_web),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model: word i preloads to A5A5_0000 | i while ram_reset is high; full-word writes.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (ram_reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            ram_dout <= '0;
        end else begin
            ram_dout <= mem[ram_addr[7:2]];
            if (ram_web != 4'b0000) mem[ram_addr[7:2]] <= ram_din;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per response pulse.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
            if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp1_valid}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {31'd0, rsp1_valid}, {31'd0, e[32]});
                chk("rsp_rdata", e[32] ? rsp1_rdata : rsp0_rdata, e[31:0]);
                chk("rsp_other_rdata", e[32] ? rsp0_rdata : rsp1_rdata, 32'd0);
            end
        end
    end

    // One cycle of stimulus with hand-computed grants, ram_reset and response data.
    task automatic cyc(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] be0, input logic v1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [3:0] be1, input logic g0,
                       input logic g1, input logic rr, input logic [31:0] exp_data,
                       input bit push);
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        @(negedge clk);
        #1;
        req0_valid = v0; req0_addr = a0; req0_wdata = d0; req0_be = be0;
        req1_valid = v1; req1_addr = a1; req1_wdata = d1; req1_be = be1;
        #1;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        chk("ram_reset", {31'd0, ram_reset}, {31'd0, rr});
        ea = g0 ? a0 : (g1 ? a1 : 32'd0);
        ed = g0 ? d0 : (g1 ? d1 : 32'd0);
        ew = g0 ? be0 : (g1 ? be1 : 4'd0);
        chk("ram_addr", ram_addr, ea);
        chk("ram_din", ram_din, ed);
        chk("ram_web", {28'd0, ram_web}, {28'd0, ew});
        if (push && (g0 || g1)) exp_q.push_back({g1, exp_data});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
        chk({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
        chk({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
        chk({tag, "_rsp0_rdata"}, rsp0_rdata, 32'd0);
        chk({tag, "_rsp1_rdata"}, rsp1_rdata, 32'd0);
        chk({tag, "_ram_reset"}, {31'd0, ram_reset}, 32'd1);
        chk({tag, "_ram_web"}, {28'd0, ram_web}, 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_din"}, ram_din, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic g;
        reset = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_wdata = 0; req0_be = 0;
        req1_valid = 0; req1_addr = 0; req1_wdata = 0; req1_be = 0;
        #2 reset = 1'b0;
        #4 chk_reset_outputs("por");
        req0_valid = 1'b1; req1_valid = 1'b1; req1_addr = 32'h8;
        #10 chk_reset_outputs("por_valid");
        reset = 1'b1;

        // INIT: four cycles of ram_reset with both requesters waiting
        for (int i = 0; i < 4; i++) cyc(1, 32'h0, 0, 0, 1, 32'h8, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h0, 0, 0, 1, 32'h8, 0, 0, 1, 0, 0, 32'hA5A5_0000, 1);

        // Write by req0, read-back by req1
        cyc(1, 32'h80, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 1, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 1);
        idle();

        // Continuous contention
        for (int i = 0; i < 18; i++) begin
            g = GuardOn && (i == 8 || i == 17);
            cyc(1, 32'h4, 0, 0, 1, 32'h8, 0, 0, !g, g, 0,
                g ? 32'hA5A5_0002 : 32'hA5A5_0001, 1);
        end
        idle();

        // Back-to-back alternating reads, then write/read of the same word
        cyc(1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hA5A5_0000, 1);
        cyc(0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 1, 0, 32'hA5A5_0001, 1);
        cyc(1, 32'h8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hA5A5_0002, 1);
        cyc(0, 0, 0, 0, 1, 32'h84, 32'h1234_5678, 4'h1, 0, 1, 0, 32'd0, 1);
        cyc(1, 32'h84, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1234_5678, 1);
        idle();

        // Reset right after a read is accepted: its response must never appear
        cyc(1, 32'hC, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hA5A5_0003, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h80, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hA5A5_0020, 1);
        idle();
        idle();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data port (port B) of the unified instruction/data RAM between two requesters: the core load/store unit (requester 0) and the program loader/debug master (requester 1). It sequences RAM initialisation after reset, grants at most one access per cycle, and routes the one-cycle-latency read data back to the requester that issued it. It sits between the requesters and RAM port B. Port A (instruction fetch) is not touched.

## Interface
Parameters:
- INIT_CYCLES, 4: cycles `ram_reset` is held high after reset release, before any grant.
- MAX_WAIT, 8: maximum cycles requester 1 may wait while requester 0 wins. Used only with the starvation guard.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- req0_valid / req1_valid  in  1  access request.
- req0_addr / req1_addr  in  32  byte address. Forwarded unmodified; the RAM word-aligns it.
- req0_wdata / req1_wdata  in  32  write data.
- req0_be / req1_be  in  4  byte enables. Nonzero = write; 0000 = read.
- req0_ready / req1_ready  out  1  grant. Combinational; the access is accepted in a cycle with valid&ready.
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse, the cycle after acceptance (reads and writes).
- rsp0_rdata / rsp1_rdata  out  32  read data. Valid with rsp_valid for reads; 0 for writes.
- ram_reset  out  1  active-high synchronous RAM reset/preload strobe.
- ram_addr  out  32  to RAM addrB.
- ram_web  out  4  to RAM web.
- ram_din  out  32  to RAM dinB.
- ram_dout  in  32  from RAM doutB.

## Operation
- FSM states are INIT and RUN.
  - Reset assertion forces INIT asynchronously. In INIT, `ram_reset` = 1, all readys = 0, and the init counter counts 0 to INIT_CYCLES-1.
  - The counter reaching INIT_CYCLES-1 moves the FSM to RUN, with `ram_reset` = 0. RUN never leaves except on reset.
- Grant rules in RUN:
  - Only one requester valid: it is granted.
  - Both valid: requester 0 wins, unless the starvation guard fires (see Configuration).
  - ready is never asserted to a requester whose valid is 0.
- RAM drive:
  - Granted requester's addr/wdata/be go to ram_addr/ram_din/ram_web.
  - With no grant: ram_web = 0000, ram_addr = 0, ram_din = 0. This is an idle read of word 0, and its result is discarded.
- Response tracking:
  - A registered pending flag plus a 1-bit owner ID and a write bit are captured at acceptance.
  - Next cycle: rspN_valid is pulsed for that owner. rspN_rdata = ram_dout if it was a read, else 0.
  - The non-owner rsp_valid = 0 and its rdata = 0.
- Back-to-back accesses are allowed every cycle, to either requester. Responses stay strictly in acceptance order.
- Write response ack: the RAM writes the full word (byte masking is not honoured by the RAM). The arbiter does not merge bytes.

## Timing
- Reset values of every output: all ready = 0, all rsp_valid = 0, all rsp_rdata = 0, ram_reset = 1, ram_web = 0000, ram_addr = 0, ram_din = 0.
- First grant is possible at the INIT_CYCLES+1-th rising edge after reset deasserts.
- Latency: request accepted at edge N; rsp_valid and rdata are valid during cycle N+1 and sampled at edge N+1.
- Throughput is 1 access per cycle.
- Reset asserted mid-access: the pending response is dropped and no rsp_valid is produced. The FSM restarts in INIT.
- Simultaneous write by requester 1 and read by requester 0 to the same address: requester 0 reads first. Requester 1's write is accepted later and is ordered after the read.
- Read of an address written in the previous cycle returns the new data.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A wait counter of width clog2(MAX_WAIT+1) increments each cycle that req1_valid is 1 and req1 is not granted.
  - When the counter equals MAX_WAIT, requester 1 wins the next contended cycle. The counter clears on a requester 1 grant or when req1_valid = 0.
  - The counter saturates and is reset to 0.
- `ARB_STARVE_GUARD_EN` undefined: strict priority for requester 0. The counter and the MAX_WAIT logic are absent, and requester 1 may starve indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - state enum {INIT, RUN}
  - requester ID constants REQ_CORE = 0, REQ_LOADER = 1
  - BE_READ = 4'b0000
  - default INIT_CYCLES and MAX_WAIT
- Sub-module `mem_arb_age_counter`: the starvation counter, instantiated only under `ARB_STARVE_GUARD_EN`. The rest is flat.

## Test plan
- Reset release, INIT_CYCLES=4, both valid from reset -> ram_reset high for 4 cycles, ready=0 throughout; the first grant goes to req0 in the 5th cycle.
- req0 write be=1111, addr=0x80, data=0xDEADBEEF, then req1 read of 0x80 -> rsp0_valid pulse with rdata 0; rsp1_rdata = 0xDEADBEEF one cycle after its grant.
- Both valid continuously, guard on, MAX_WAIT=8 -> req1 granted exactly once every 9 cycles. With guard off -> req1 never granted.
- Alternating reads req0 0x0, req1 0x4, req0 0x8 every cycle -> responses in the same order, each rsp_valid on the correct requester only, data matching preload words.
- Reset pulled low the cycle after a read is accepted -> no rsp_valid, all outputs return to reset values immediately, INIT re-entered.
